// File: rtl/ifetch_unit_pkg.sv
// Shared core definitions for the instruction fetch stage.
// Holds datapath widths, the decode NOP filler and the FIFO entry layout.
package ifetch_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0013;
  localparam logic [XLEN-1:0]    RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer: synchronous FIFO with flush and occupancy count.
// Flush has priority over push/pop; pointers wrap naturally (power-of-two depth).
module ifetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

  // The issue rule upstream reserves space for every in-flight word.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && (count == CNT_W'(DEPTH))));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !flush && (count == '0)));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues SRAM reads, buffers returned
// words and hands them to decode over valid/ready; redirects flush everything.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [XLEN-1:0]    mem_addr_o,
  output logic [XLEN-1:0]    mem_wdata_o,
  input  logic [INSTR_W-1:0] mem_rdata_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [XLEN-1:0]    instr_pc_o,
  input  logic               instr_ready_i
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  inflight_pc;
  logic             inflight;
  logic [CNT_W-1:0] count;
  logic [OCC_W-1:0] occupancy;
  logic             pop;
  logic             issue;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  assign pop = instr_valid_o & instr_ready_i;

  // Buffered plus in-flight words, crediting this cycle's pop so a full
  // pipeline still sustains one fetch per cycle.
  assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
  assign issue     = rst_i && !redirect_i && (occupancy < OCC_W'(FIFO_DEPTH));

  assign mem_req_o   = issue;
  assign mem_we_o    = 1'b0;
  assign mem_addr_o  = {2'b00, pc[XLEN-1:2]};
  assign mem_wdata_o = '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_i) begin
      pc       <= redirect_pc_i & ~XLEN'(3);
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + XLEN'(4);
      end
    end
  end

  assign push_entry.pc    = inflight_pc;
  assign push_entry.instr = mem_rdata_i;

  // Flush on redirect also discards the returning word and any same-cycle pop.
  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (inflight),
    .pop   (pop),
    .flush (redirect_i),
    .wdata (push_entry),
    .rdata (head),
    .count (count)
  );

  assign instr_valid_o = (count != '0);
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: cold start, stall, redirects, PC wrap and
// asynchronous reset, with a behavioural one-cycle-latency SRAM per instance.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ready = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        ivalid;
  logic [31:0] instr, ipc;

  logic        w_req, w_we;
  logic [31:0] w_addr, w_wdata, w_rdata;
  logic        w_valid;
  logic [31:0] w_instr, w_pc;
  logic        w_ready = 1'b1;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk_i(clk), .rst_i(rst),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(ivalid), .instr_o(instr), .instr_pc_o(ipc),
    .instr_ready_i(ready)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk_i(clk), .rst_i(rst),
    .mem_req_o(w_req), .mem_we_o(w_we), .mem_addr_o(w_addr),
    .mem_wdata_o(w_wdata), .mem_rdata_i(w_rdata),
    .redirect_i(w_redirect), .redirect_pc_i(w_redirect_pc),
    .instr_valid_o(w_valid), .instr_o(w_instr), .instr_pc_o(w_pc),
    .instr_ready_i(w_ready)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0000_0000;
      32'd1:   return 32'h0020_81B3;
      32'd2:   return 32'h4052_0333;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_req) mem_rdata <= word_at(mem_addr);
    if (w_req)   w_rdata   <= word_at(w_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] word);
    check({tag, ".valid"}, 32'(ivalid), 32'd1);
    check({tag, ".pc"}, ipc, pc);
    check({tag, ".instr"}, instr, word);
  endtask

  task automatic check_req(input string tag, input logic [31:0] addr);
    check({tag, ".req"}, 32'(mem_req), 32'd1);
    check({tag, ".addr"}, mem_addr, addr);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #23;
    check("rst.req", 32'(mem_req), 32'd0);
    check("rst.valid", 32'(ivalid), 32'd0);
    check("rst.instr", instr, 32'h0);
    check("rst.pc", ipc, 32'h0);
    rst = 1'b1;
    #1;
    // cold start; wrap instance runs in lockstep
    check_req("c0", 32'd0);
    check("c0.valid", 32'(ivalid), 32'd0);
    check("c0.we", 32'(mem_we), 32'd0);
    check("c0.wdata", mem_wdata, 32'h0);
    check("w0.addr", w_addr, 32'h3FFF_FFFE);
    cyc; #1;
    check_req("c1", 32'd1);
    check("c1.valid", 32'(ivalid), 32'd0);
    check("w1.addr", w_addr, 32'h3FFF_FFFF);
    cyc; #1;
    check_req("c2", 32'd2);
    check_head("c2", 32'h0, 32'h0);
    check("w2.addr", w_addr, 32'h0);
    check("w2.pc", w_pc, 32'hFFFF_FFF8);
    check("w2.instr", w_instr, 32'hC0DE_FFFE);
    check("w2.we", 32'(w_we), 32'd0);
    cyc; ready = 1'b0;
    // decode stall for five cycles
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall.req", 32'(mem_req), 32'd0);
      check_head("stall", 32'h4, 32'h0020_81B3);
      if (i == 0) begin
        check("w3.pc", w_pc, 32'hFFFF_FFFC);
        check("w3.instr", w_instr, 32'hC0DE_FFFF);
      end
      if (i == 1) begin
        check("w4.valid", 32'(w_valid), 32'd1);
        check("w4.pc", w_pc, 32'h0);
        check("w4.instr", w_instr, 32'h0);
      end
      cyc;
    end
    ready = 1'b1;
    #1;
    check_req("c8", 32'd3);
    check_head("c8", 32'h4, 32'h0020_81B3);
    cyc; #1;
    check_req("c9", 32'd4);
    check_head("c9", 32'h8, 32'h4052_0333);
    cyc; #1;
    check_head("c10", 32'hC, 32'hC0DE_0003);
    cyc; #1;
    check_head("c11", 32'h10, 32'hC0DE_0004);
    // redirect to 0x16 with a fetch in flight
    cyc; redirect = 1'b1; redirect_pc = 32'h16; #1;
    check("c12.req", 32'(mem_req), 32'd0);
    check_head("c12", 32'h14, 32'hC0DE_0005);
    cyc; redirect = 1'b0; #1;
    check("c13.valid", 32'(ivalid), 32'd0);
    check_req("c13", 32'd5);
    cyc; #1;
    check("c14.valid", 32'(ivalid), 32'd0);
    check_req("c14", 32'd6);
    // redirect coincident with pop and push
    cyc; redirect = 1'b1; redirect_pc = 32'h0; #1;
    check_head("c15", 32'h14, 32'hC0DE_0005);
    check("c15.req", 32'(mem_req), 32'd0);
    cyc; redirect = 1'b0; #1;
    check("c16.valid", 32'(ivalid), 32'd0);
    check_req("c16", 32'd0);
    cyc; #1;
    check("c17.valid", 32'(ivalid), 32'd0);
    check_req("c17", 32'd1);
    cyc; #1;
    check_head("c18", 32'h0, 32'h0);
    // back-to-back redirects, last wins
    cyc; redirect = 1'b1; redirect_pc = 32'h100; #1;
    check("c19.req", 32'(mem_req), 32'd0);
    check_head("c19", 32'h4, 32'h0020_81B3);
    cyc; redirect_pc = 32'h208; #1;
    check("c20.req", 32'(mem_req), 32'd0);
    check("c20.valid", 32'(ivalid), 32'd0);
    cyc; redirect = 1'b0; #1;
    check_req("c21", 32'h82);
    check("c21.valid", 32'(ivalid), 32'd0);
    cyc; #1;
    check_req("c22", 32'h83);
    cyc; #1;
    check_head("c23", 32'h208, 32'hC0DE_0082);
    // redirect while full and stalled
    cyc; ready = 1'b0; #1;
    check("c24.req", 32'(mem_req), 32'd0);
    check_head("c24", 32'h20C, 32'hC0DE_0083);
    cyc; redirect = 1'b1; redirect_pc = 32'h43; #1;
    check("c25.req", 32'(mem_req), 32'd0);
    check_head("c25", 32'h20C, 32'hC0DE_0083);
    cyc; redirect = 1'b0; ready = 1'b1; #1;
    check("c26.valid", 32'(ivalid), 32'd0);
    check_req("c26", 32'h10);
    cyc; #1;
    check_req("c27", 32'h11);
    cyc; #1;
    check_head("c28", 32'h40, 32'hC0DE_0010);
    // asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    check("arst.req", 32'(mem_req), 32'd0);
    check("arst.valid", 32'(ivalid), 32'd0);
    check("arst.instr", instr, 32'h0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_req("r0", 32'd0);
    check("r0.valid", 32'(ivalid), 32'd0);
    cyc; #1;
    check_req("r1", 32'd1);
    check("r1.valid", 32'(ivalid), 32'd0);
    cyc; #1;
    check_head("r2", 32'h0, 32'h0);
    cyc; #1;
    check_head("r3", 32'h4, 32'h0020_81B3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the core's instruction SRAM.
- Owns the PC and issues word-indexed read requests to the SRAM (one-cycle read latency, registered address, no ready).
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
- FIFO_DEPTH, 2, instruction buffer entries. Legal values: power of two, >= 2.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous reset, active-low. Asserting low resets all state immediately.
- mem_req_o  out  1  SRAM request.
- mem_we_o  out  1  SRAM write enable; tied 0.
- mem_addr_o  out  32  SRAM word index = {2'b00, pc[31:2]}.
- mem_wdata_o  out  32  tied 0.
- mem_rdata_i  in  32  SRAM read data; valid the cycle after an accepted request.
- redirect_i  in  1  redirect strobe from execute (taken branch or jump).
- redirect_pc_i  in  32  redirect byte target; bits [1:0] ignored.
- instr_valid_o  out  1  FIFO head valid.
- instr_o  out  32  instruction word at FIFO head.
- instr_pc_o  out  32  byte PC of instr_o.
- instr_ready_i  in  1  decode accepts the head this cycle.

Behaviour:
- Reset values: pc = RESET_PC; FIFO empty (count = 0, pointers = 0); inflight = 0.
- Outputs in reset: mem_req_o = 0, instr_valid_o = 0, instr_o = 0, instr_pc_o = 0.
- pop = instr_valid_o & instr_ready_i.
- Issue rule (combinational): mem_req_o = !redirect_i && (count + inflight - pop) < FIFO_DEPTH. The pop credit sustains 1 instr/cycle.
- On an issue edge:
  - inflight <= 1
  - inflight_pc <= pc
  - pc <= pc + 4; 32-bit wrap, 0xFFFF_FFFC + 4 = 0.
- Otherwise inflight <= 0.
- Response: when inflight = 1, mem_rdata_i is pushed into the FIFO at that edge with inflight_pc, unless killed. Space is guaranteed by the issue rule, so overflow is impossible. An overflow is an assertion failure.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo FIFO_DEPTH.
- Latency: request in cycle N -> instr_valid_o high in cycle N+2.
- instr_o and instr_pc_o hold stable while instr_valid_o = 1 and instr_ready_i = 0. Standard valid/ready rule: valid never drops without a pop or a redirect.
- Redirect (highest priority, single cycle), at the edge:
  - FIFO flushed: count = 0, pointers = 0.
  - The in-flight response is discarded; inflight <= 0, no push.
  - pc <= {redirect_pc_i[31:2], 2'b00}.
  - mem_req_o = 0 that cycle; the first request at the target is issued the next cycle.
  - pop is ignored in a redirect cycle; decode must not count it as consumed.
- Back-to-back redirects: the last one wins; no fetch is issued between them.
- Redirect while the FIFO is full or decode is stalled: same behaviour, flush unconditional.
- Reset asserted mid-operation: all state returns to reset values asynchronously. Any SRAM read in flight is ignored after reset release.
- No write traffic is ever generated.

Decomposition:
- Shared core package holds:
  - XLEN = 32
  - INSTR_W = 32
  - NOP = 32'h0000_0013, used by decode when instr_valid_o = 0
  - the RESET_PC default
- One sub-module: ifetch_fifo, a synchronous FIFO with:
  - parameterised depth and width
  - push/pop/flush inputs
  - count output
  - Entry width = 64 (pc, instr).
- PC, inflight logic and the issue rule stay in ifetch_unit.

Test Plan:
- Cold start: SRAM preloaded so word1 = 0x002081B3 and word2 = 0x40520333; rst_i released, ready = 1.
  -> mem_addr_o = 0, 1, 2 in consecutive cycles.
  -> instr 0x0000_0000 at pc 0, then 0x002081B3 at pc 4, then 0x40520333 at pc 8, on consecutive cycles from cycle 2.
- Decode stall: hold ready = 0 for 5 cycles.
  -> exactly 2 words buffered; mem_req_o low while the FIFO is full.
  -> head stays (0x002081B3, pc 4).
  -> on release, words delivered in order with no gap or duplicate.
- Redirect with an in-flight fetch: redirect_i = 1, redirect_pc_i = 0x16.
  -> FIFO empty and in-flight response dropped.
  -> next request has mem_addr_o = 5; first valid instr is at pc 0x14.
- Redirect coincident with pop and push: FIFO count 1, inflight = 1, ready = 1, redirect to 0x0.
  -> count 0 after the edge, no stale word delivered, next instr_pc_o = 0.
- PC wrap: RESET_PC = 0xFFFF_FFF8.
  -> mem_addr_o sequence 0x3FFF_FFFE, 0x3FFF_FFFF, 0x0000_0000.
  -> instr_pc_o sequence FFF8, FFFC, 0.
- Asynchronous reset mid-fetch: drop rst_i between clock edges.
  -> mem_req_o and instr_valid_o go 0 immediately.
  -> after release, the fetch restarts at RESET_PC.
